rom_arbiter: RTL and testbench

- Shares the single-port, combinational-read instruction ROM between two requesters.
- Requester 1 is the CPU instruction fetch path.
- Requester 2 is a debug dump engine that streams a block of ROM words out over a valid/ready port.
- The CPU has fixed priority, and a starvation guard guarantees the debug engine forward progress.
- Read data is registered, so the ROM-to-consumer timing path is broken here.

---
 rtl/hack_mem_pkg.sv | 15 +
 rtl/rom_dump_engine.sv | 110 +++++++++++
 rtl/rom_arbiter.sv | 101 ++++++++++
 tb/tb_rom_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// Shared definitions for the instruction-ROM access path.
// Holds the default ROM geometry (32K x 16) and the debug dump FSM state encoding.
package hack_mem_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_OUT   = 2'd2,
    ST_DONE  = 2'd3
  } dbg_state_e;

endpackage

// File: rtl/rom_dump_engine.sv
// Debug dump engine: walks a block of ROM words starting at a latched base
// address and presents each word on a valid/ready port.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   dbg_start          start pulse; dbg_base/dbg_len sampled with it (IDLE only)
//   dbg_base, dbg_len  dump start address and word count
//   dbg_gnt            arbiter grant: rom_data belongs to dbg_addr this cycle
//   rom_data           combinational ROM output
//   dbg_req, dbg_addr  ROM request and address toward the arbiter
//   dbg_busy           dump in progress (FETCH, OUT, DONE)
//   dbg_valid/ready    output handshake, dbg_data the dumped word
//   dbg_done           one-cycle completion pulse
module rom_dump_engine
  import hack_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dbg_start,
  input  logic [ADDR_W-1:0] dbg_base,
  input  logic [ADDR_W:0]   dbg_len,
  input  logic              dbg_gnt,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              dbg_ready,
  output logic              dbg_req,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_busy,
  output logic              dbg_valid,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_done
);

  dbg_state_e        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_cnt;
  logic              r_busy;
  logic              r_valid;
  logic              r_done;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W:0]   w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + (ADDR_W+1)'(1);

  // Address arithmetic is ADDR_W wide so a dump running past the top wraps to 0.
  assign dbg_addr  = r_base + r_cnt[ADDR_W-1:0];
  assign dbg_req   = (r_state == ST_FETCH);
  assign dbg_busy  = r_busy;
  assign dbg_valid = r_valid;
  assign dbg_data  = r_data;
  assign dbg_done  = r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (dbg_start) begin
            r_busy <= 1'b1;
            if (dbg_len != '0) begin
              r_base  <= dbg_base;
              r_len   <= dbg_len;
              r_cnt   <= '0;
              r_state <= ST_FETCH;
            end else begin
              // Empty dump: report completion without producing data.
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_FETCH: begin
          if (dbg_gnt) begin
            r_data  <= rom_data;
            r_valid <= 1'b1;
            r_state <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (dbg_ready) begin
            r_valid <= 1'b0;
            r_cnt   <= w_cnt_nxt;
            if (w_cnt_nxt == r_len) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the single-port combinational instruction ROM between the CPU fetch
// path (fixed priority) and the debug dump engine. A starvation counter forces
// a debug grant after STARVE_LIMIT consecutive denied debug cycles. CPU read
// data is registered: a grant at one edge yields cpu_valid/cpu_data after the next.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   cpu_req/cpu_addr        CPU fetch request; cpu_gnt combinational accept
//   cpu_valid/cpu_data      registered CPU read response
//   dbg_start/base/len      dump control; dbg_busy, dbg_done status
//   dbg_valid/ready/data    dump output handshake
//   rom_addr/rom_data       ROM interface
module rom_arbiter
  import hack_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_data,
  input  logic              dbg_start,
  input  logic [ADDR_W-1:0] dbg_base,
  input  logic [ADDR_W:0]   dbg_len,
  output logic              dbg_busy,
  output logic              dbg_valid,
  input  logic              dbg_ready,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int            SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic              w_dbg_req;
  logic [ADDR_W-1:0] w_dbg_addr;
  logic              w_force;
  logic              w_dbg_win;
  logic [SW-1:0]     r_starve;
  logic              r_cpu_valid;
  logic [DATA_W-1:0] r_cpu_data;

  rom_dump_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_dump (
    .clk       (clk),
    .reset     (reset),
    .dbg_start (dbg_start),
    .dbg_base  (dbg_base),
    .dbg_len   (dbg_len),
    .dbg_gnt   (w_dbg_win),
    .rom_data  (rom_data),
    .dbg_ready (dbg_ready),
    .dbg_req   (w_dbg_req),
    .dbg_addr  (w_dbg_addr),
    .dbg_busy  (dbg_busy),
    .dbg_valid (dbg_valid),
    .dbg_data  (dbg_data),
    .dbg_done  (dbg_done)
  );

  // CPU wins unless the debug engine has been starved long enough.
  assign w_force   = (r_starve == LIMIT);
  assign w_dbg_win = w_dbg_req && (!cpu_req || w_force);
  assign cpu_gnt   = cpu_req && !w_dbg_win;
  assign rom_addr  = w_dbg_win ? w_dbg_addr : cpu_addr;

  assign cpu_valid = r_cpu_valid;
  assign cpu_data  = r_cpu_data;

  // Starve counter saturates naturally: once at LIMIT a pending debug request wins and clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (!w_dbg_req || w_dbg_win) begin
      r_starve <= '0;
    end else if (cpu_req && !w_force) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // CPU response stage: capture the ROM word at the grant edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_valid <= 1'b0;
      r_cpu_data  <= '0;
    end else begin
      r_cpu_valid <= cpu_gnt;
      if (cpu_gnt) r_cpu_data <= rom_data;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
module tb_rom_arbiter;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int LIMIT  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_gnt;
  logic              cpu_valid;
  logic [DATA_W-1:0] cpu_data;
  logic              dbg_start;
  logic [ADDR_W-1:0] dbg_base;
  logic [ADDR_W:0]   dbg_len;
  logic              dbg_busy;
  logic              dbg_valid;
  logic              dbg_ready;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_done;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  int total = 0;
  int bad   = 0;

  // ROM contents: a fixed scramble of the address so every word is distinct.
  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    return {1'b1, a} ^ 16'h5A3C;
  endfunction

  assign rom_data = rom_fn(rom_addr);

  always #5 clk = ~clk;

  rom_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_gnt   (cpu_gnt),
    .cpu_valid (cpu_valid),
    .cpu_data  (cpu_data),
    .dbg_start (dbg_start),
    .dbg_base  (dbg_base),
    .dbg_len   (dbg_len),
    .dbg_busy  (dbg_busy),
    .dbg_valid (dbg_valid),
    .dbg_ready (dbg_ready),
    .dbg_data  (dbg_data),
    .dbg_done  (dbg_done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
    dbg_start = 1'b1;
    dbg_base  = base;
    dbg_len   = len;
    step();
    dbg_start = 1'b0;
  endtask

  // Consumes a running dump, stalling each word `stall` cycles before accepting it.
  task automatic dump_collect(input logic [ADDR_W-1:0] base, input int len,
                              input int stall, input bit chk_gap);
    int k = 0, st = 0, cyc = 0, last_hs = -10, done_cyc = -1;
    bit prev_hs = 1'b0;
    logic [DATA_W-1:0] expw;
    while (cyc < 300 && done_cyc < 0) begin
      if (prev_hs) chk("valid_drop", dbg_valid, 0);
      prev_hs = 1'b0;
      if (dbg_done) begin
        done_cyc = cyc;
      end else if (dbg_valid) begin
        expw = rom_fn(base + ADDR_W'(k));
        chk("dbg_data", dbg_data, expw);
        if (st < stall) begin
          dbg_ready = 1'b0;
          st++;
        end else begin
          dbg_ready = 1'b1;
          st = 0;
          if (chk_gap && k > 0) chk("hs_gap", cyc - last_hs, 2);
          last_hs = cyc;
          k++;
          prev_hs = 1'b1;
        end
      end else begin
        dbg_ready = 1'b0;
      end
      if (done_cyc < 0) begin
        step();
        cyc++;
      end
    end
    chk("word_count", k, len);
    chk("done_timing", done_cyc, last_hs + 1);
    dbg_ready = 1'b0;
    step();
    chk("busy_after", dbg_busy, 0);
    chk("done_one_cycle", dbg_done, 0);
  endtask

  typedef struct {
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              exp_gnt;
    logic              exp_valid;
    logic [DATA_W-1:0] exp_data;
  } cpu_vec_t;

  cpu_vec_t vec[5];

  initial begin
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_addr  = '0;
    dbg_start = 1'b0;
    dbg_base  = '0;
    dbg_len   = '0;
    dbg_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_cpu_valid", cpu_valid, 0);
    chk("rst_cpu_data", cpu_data, 0);
    chk("rst_dbg_valid", dbg_valid, 0);
    chk("rst_dbg_data", dbg_data, 0);
    chk("rst_dbg_busy", dbg_busy, 0);
    chk("rst_dbg_done", dbg_done, 0);
    reset = 1'b0;

    // Test 1: CPU only, table-driven
    vec[0] = '{1'b1, 15'd0, 1'b1, 1'b0, 16'h0000};
    vec[1] = '{1'b1, 15'd1, 1'b1, 1'b1, rom_fn(15'd0)};
    vec[2] = '{1'b1, 15'd2, 1'b1, 1'b1, rom_fn(15'd1)};
    vec[3] = '{1'b0, 15'd0, 1'b0, 1'b1, rom_fn(15'd2)};
    vec[4] = '{1'b0, 15'd0, 1'b0, 1'b0, rom_fn(15'd2)};
    for (int i = 0; i < 5; i++) begin
      cpu_req  = vec[i].req;
      cpu_addr = vec[i].addr;
      #1;
      chk($sformatf("t1_gnt[%0d]", i), cpu_gnt, vec[i].exp_gnt);
      chk($sformatf("t1_valid[%0d]", i), cpu_valid, vec[i].exp_valid);
      chk($sformatf("t1_data[%0d]", i), cpu_data, vec[i].exp_data);
      step();
    end

    // Test 2: idle dump
    cpu_req = 1'b0;
    start_dump(15'h0010, 16'd4);
    chk("t2_busy", dbg_busy, 1);
    chk("t2_rom_addr", rom_addr, 15'h0010);
    dump_collect(15'h0010, 4, 0, 1'b1);

    // Test 3: contention with cpu_req held high
    cpu_req  = 1'b1;
    cpu_addr = 15'h0100;
    dbg_ready = 1'b1;
    dbg_start = 1'b1;
    dbg_base  = 15'h0040;
    dbg_len   = 16'd2;
    #1;
    chk("t3_start_cpu_gnt", cpu_gnt, 1);
    step();
    dbg_start = 1'b0;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < LIMIT; i++) begin
        chk($sformatf("t3_denied_gnt[%0d]", i), cpu_gnt, 1);
        chk($sformatf("t3_denied_addr[%0d]", i), rom_addr, 15'h0100);
        step();
      end
      chk("t3_forced_cpu_gnt", cpu_gnt, 0);
      chk("t3_forced_addr", rom_addr, 15'h0040 + 15'(w));
      step();
      chk("t3_cpu_valid_gap", cpu_valid, 0);
      chk("t3_dbg_valid", dbg_valid, 1);
      chk("t3_dbg_data", dbg_data, rom_fn(15'h0040 + 15'(w)));
      chk("t3_out_cpu_gnt", cpu_gnt, 1);
      step();
      chk("t3_cpu_valid_back", cpu_valid, 1);
      chk("t3_cpu_data", cpu_data, rom_fn(15'h0100));
    end
    chk("t3_done", dbg_done, 1);
    step();
    chk("t3_idle", dbg_busy, 0);
    cpu_req   = 1'b0;
    dbg_ready = 1'b0;

    // Test 4: backpressure and address wrap
    start_dump(15'h7FFE, 16'd3);
    dump_collect(15'h7FFE, 3, 5, 1'b0);

    // Test 5a: zero-length dump
    start_dump(15'h0123, 16'd0);
    chk("t5_len0_done", dbg_done, 1);
    chk("t5_len0_busy", dbg_busy, 1);
    chk("t5_len0_valid", dbg_valid, 0);
    step();
    chk("t5_len0_done_off", dbg_done, 0);
    chk("t5_len0_busy_off", dbg_busy, 0);
    chk("t5_len0_valid_off", dbg_valid, 0);

    // Test 5b: start while busy is ignored
    start_dump(15'h0200, 16'd2);
    dbg_start = 1'b1;
    dbg_base  = 15'h0300;
    dbg_len   = 16'd5;
    step();
    dbg_start = 1'b0;
    dump_collect(15'h0200, 2, 2, 1'b0);

    // Test 6: reset while in OUT
    cpu_req = 1'b1;
    cpu_addr = 15'h0077;
    step();
    cpu_req = 1'b0;
    start_dump(15'h0055, 16'd3);
    step();
    chk("t6_in_out", dbg_valid, 1);
    reset = 1'b1;
    step();
    chk("t6_cpu_valid", cpu_valid, 0);
    chk("t6_cpu_data", cpu_data, 0);
    chk("t6_dbg_valid", dbg_valid, 0);
    chk("t6_dbg_data", dbg_data, 0);
    chk("t6_dbg_busy", dbg_busy, 0);
    chk("t6_dbg_done", dbg_done, 0);
    reset = 1'b0;
    dbg_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t6_no_done[%0d]", i), dbg_done, 0);
      chk($sformatf("t6_no_valid[%0d]", i), dbg_valid, 0);
    end
    dbg_ready = 1'b0;
    start_dump(15'h1234, 16'd1);
    dump_collect(15'h1234, 1, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
